layer_sched: RTL and testbench
==============================

Name: layer_sched

Overview:
- Frame write scheduler that sits between the host byte stream (SPI/FIFO side) and the array of layer_out instances, one instance per cube layer.
- Counts incoming colour bytes and routes each one to the correct layer, pixel address and byte lane.
- Issues the write strobes the layer buffers expect, and pulses a common frame-ready once a complete frame has been written.
- Detects and reports truncated frames and stray bytes.

Parameters:
- LAYER_NUM, 8, number of layer_out instances; width of layer_en_out.
- PIXEL_NUM, 64, pixels per layer; must be ≤ 64 because wr_addr_out is 6 bits.
- BYTE_NUM, 3, colour bytes per pixel; must be 1..4.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-high reset.
- frame_start_in  input  1  single-cycle pulse; begins a new frame.
- byte_vld_in  input  1  byte_data_in is valid this cycle; no backpressure exists.
- byte_data_in  input  8  colour byte.
- layer_en_out  output  LAYER_NUM  one-hot select of the target layer; all-zero when no write.
- wr_addr_out  output  6  pixel index within the layer.
- byte_en_out  output  4  one-hot byte-lane strobe; all-zero when no write.
- byte_data_out  output  8  registered copy of the accepted byte.
- frame_rdy_out  output  1  single-cycle pulse to all layers once the frame is complete.
- busy_out  output  1  high while a frame is loading or committing.
- frame_err_out  output  1  single-cycle pulse on abort or stray byte.

Behaviour:
- States: IDLE, LOAD, COMMIT. Internal counters: byte_cnt (0..BYTE_NUM-1), pix_cnt (0..PIXEL_NUM-1), lay_cnt (0..LAYER_NUM-1).
- Reset (asynchronous, any time, including mid-frame):
  - state goes to IDLE and all counters to 0.
  - All outputs go to 0.
  - No frame_rdy_out pulse is issued for a partial frame.
- IDLE:
  - frame_start_in moves to LOAD and clears the counters.
  - byte_vld_in without frame_start_in drops the byte and pulses frame_err_out on the next cycle.
- LOAD, for each byte_vld_in (or byte_vld_in in the same cycle as frame_start_in):
  - Next cycle, drive layer_en_out = 1<<lay_cnt, wr_addr_out = pix_cnt, byte_en_out = 1<<byte_cnt, byte_data_out = byte_data_in.
  - Write outputs hold for exactly one cycle, then return to zero (except byte_data_out, which holds its value).
  - Latency from input to strobe is exactly 1 cycle. Back-to-back bytes every cycle must be sustained.
- Counter advance:
  - byte_cnt increments; on wrap to 0, pix_cnt increments.
  - On pix_cnt wrap, lay_cnt increments.
  - Order: byte fastest, then pixel, then layer. Layer 0, pixel 0, byte 0 is first.
- Last byte (lay_cnt = LAYER_NUM-1, pix_cnt = PIXEL_NUM-1, byte_cnt = BYTE_NUM-1):
  - That byte is written normally and state moves to COMMIT.
- COMMIT:
  - Lasts exactly one cycle.
  - frame_rdy_out is high in the cycle after the last write strobe, then state returns to IDLE.
  - byte_vld_in during COMMIT is dropped and pulses frame_err_out.
- frame_start_in during LOAD (abort):
  - Counters restart; frame_err_out pulses one cycle later; state stays in LOAD.
  - A byte in the same cycle becomes byte 0 of the new frame.
  - No frame_rdy_out pulse is issued for the aborted frame.
- frame_start_in during COMMIT:
  - The commit completes (frame_rdy_out still pulses) and state goes directly to LOAD.
  - A byte in the same cycle is accepted as byte 0.
- busy_out is a registered output, high in LOAD and COMMIT.
- Outputs: all registered; no combinational path from inputs to outputs.
- Frame size: LAYER_NUM*PIXEL_NUM*BYTE_NUM bytes, which is 1536 with the defaults.

Test Plan:
- Reset, then a full frame of 1536 consecutive bytes with data = index mod 256:
  - Strobes appear 1 cycle after each byte.
  - Byte 0 writes layer_en=0x01, addr=0, byte_en=0001.
  - Byte 191 writes layer_en=0x01, addr=63, byte_en=0100.
  - Byte 192 writes layer_en=0x02, addr=0, byte_en=0001.
  - frame_rdy_out pulses exactly once, 1 cycle after the final strobe (layer_en=0x80, addr=63); busy_out then drops.
- Same frame with byte_vld_in randomly gapped:
  - Identical address, lane and layer sequence; no strobes during gaps.
- frame_start_in after 500 bytes, followed by a full frame:
  - frame_err_out pulses once and no frame_rdy_out pulse occurs for the aborted frame.
  - The next strobe is layer 0, addr 0, byte_en 0001.
  - Exactly one frame_rdy_out pulse occurs after 1536 further bytes.
- Bytes in IDLE, and a byte during COMMIT:
  - Each is dropped with no strobe and pulses frame_err_out for one cycle.
- frame_start_in together with byte_vld_in (data 0xA5) in the COMMIT cycle:
  - frame_rdy_out still pulses.
  - Next cycle writes 0xA5 to layer 0, addr 0, lane 0.
- rst_in asserted mid-frame at byte 1000:
  - All outputs are 0 immediately (asynchronous).
  - No frame_rdy_out pulse occurs; after release, bytes are ignored until frame_start_in.

Source files
------------

// File: rtl/layer_sched.sv
// Frame write scheduler: routes a host colour-byte stream to per-layer buffers
// (byte fastest, then pixel, then layer) and signals frame completion or errors.
module layer_sched #(
  parameter int LAYER_NUM = 8,
  parameter int PIXEL_NUM = 64,
  parameter int BYTE_NUM  = 3
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 frame_start_in,
  input  logic                 byte_vld_in,
  input  logic [7:0]           byte_data_in,
  output logic [LAYER_NUM-1:0] layer_en_out,
  output logic [5:0]           wr_addr_out,
  output logic [3:0]           byte_en_out,
  output logic [7:0]           byte_data_out,
  output logic                 frame_rdy_out,
  output logic                 busy_out,
  output logic                 frame_err_out
);

  // Handshake: byte_vld_in qualifies byte_data_in for one cycle; there is no
  // ready, so every valid byte is either written (strobe next cycle) or dropped
  // with a frame_err_out pulse next cycle.

  localparam int LW = (LAYER_NUM > 1) ? $clog2(LAYER_NUM) : 1;
  localparam logic [1:0]    BYTE_LAST = 2'(BYTE_NUM - 1);
  localparam logic [5:0]    PIX_LAST  = 6'(PIXEL_NUM - 1);
  localparam logic [LW-1:0] LAY_LAST  = LW'(LAYER_NUM - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [5:0]    pix_cnt_q, pix_cnt_d;
  logic [LW-1:0] lay_cnt_q, lay_cnt_d;

  logic [1:0]    eff_byte;
  logic [5:0]    eff_pix;
  logic [LW-1:0] eff_lay;
  logic          accept, last, err;

  always_comb begin
    // A start pulse rewinds the position before the same-cycle byte is placed.
    eff_byte   = frame_start_in ? '0 : byte_cnt_q;
    eff_pix    = frame_start_in ? '0 : pix_cnt_q;
    eff_lay    = frame_start_in ? '0 : lay_cnt_q;
    accept     = byte_vld_in && (frame_start_in || state_q == LOAD);
    last       = (eff_byte == BYTE_LAST) && (eff_pix == PIX_LAST) && (eff_lay == LAY_LAST);
    err        = (frame_start_in && state_q == LOAD) ||
                 (byte_vld_in && !frame_start_in && state_q != LOAD);
    byte_cnt_d = eff_byte;
    pix_cnt_d  = eff_pix;
    lay_cnt_d  = eff_lay;
    state_d    = state_q;

    if (accept) begin
      if (eff_byte == BYTE_LAST) begin
        byte_cnt_d = '0;
        if (eff_pix == PIX_LAST) begin
          pix_cnt_d = '0;
          lay_cnt_d = (eff_lay == LAY_LAST) ? '0 : eff_lay + LW'(1);
        end else begin
          pix_cnt_d = eff_pix + 6'd1;
        end
      end else begin
        byte_cnt_d = eff_byte + 2'd1;
      end
    end

    case (state_q)
      IDLE:    if (frame_start_in) state_d = LOAD;
      LOAD:    state_d = LOAD;
      COMMIT:  state_d = frame_start_in ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
    if (accept && last) state_d = COMMIT;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      lay_cnt_q     <= '0;
      layer_en_out  <= '0;
      wr_addr_out   <= '0;
      byte_en_out   <= '0;
      byte_data_out <= '0;
      frame_rdy_out <= 1'b0;
      busy_out      <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      lay_cnt_q     <= lay_cnt_d;
      layer_en_out  <= accept ? (LAYER_NUM'(1) << eff_lay) : '0;
      wr_addr_out   <= accept ? eff_pix : '0;
      byte_en_out   <= accept ? (4'd1 << eff_byte) : '0;
      if (accept) byte_data_out <= byte_data_in;
      frame_rdy_out <= (state_q == COMMIT);
      busy_out      <= (state_d != IDLE);
      frame_err_out <= err;
    end
  end

endmodule

// File: tb/tb_layer_sched.sv
// Bench for layer_sched: a frame-position model checked every cycle, plus
// literal expectations on logged strobes and pulse counts.
module tb_layer_sched;
  localparam int L = 8, P = 64, B = 3, FRAME = L * P * B;

  logic       clk_in = 0, rst_in = 1, frame_start_in = 0, byte_vld_in = 0;
  logic [7:0] byte_data_in = 0;
  logic [7:0] layer_en_out;
  logic [5:0] wr_addr_out;
  logic [3:0] byte_en_out;
  logic [7:0] byte_data_out;
  logic       frame_rdy_out, busy_out, frame_err_out;

  int checks = 0, failures = 0;
  int rdy_cnt = 0, err_cnt = 0;
  logic [25:0] exp_q[$];  // logged strobes {layer_en, addr, byte_en, data}

  layer_sched #(.LAYER_NUM(L), .PIXEL_NUM(P), .BYTE_NUM(B)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start_in(frame_start_in),
    .byte_vld_in(byte_vld_in), .byte_data_in(byte_data_in),
    .layer_en_out(layer_en_out), .wr_addr_out(wr_addr_out), .byte_en_out(byte_en_out),
    .byte_data_out(byte_data_out), .frame_rdy_out(frame_rdy_out), .busy_out(busy_out),
    .frame_err_out(frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [25:0] mk(input logic [7:0] le, input logic [5:0] a,
                                     input logic [3:0] be, input logic [7:0] d);
    return {le, a, be, d};
  endfunction

  // Model: the frame is a single linear byte position; layer/pixel/lane are derived from it.
  int   m_pos = 0;
  bit   m_loading = 0, m_commit = 0, m_acc, m_next_commit;
  logic [7:0] e_layer = 0, e_data = 0;
  logic [5:0] e_addr = 0;
  logic [3:0] e_ben = 0;
  logic       e_rdy = 0, e_busy = 0, e_err = 0;

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_pos = 0; m_loading = 0; m_commit = 0;
      e_layer = 0; e_addr = 0; e_ben = 0; e_data = 0; e_rdy = 0; e_busy = 0; e_err = 0;
    end else begin
      e_rdy = m_commit;
      e_err = (frame_start_in && m_loading) || (byte_vld_in && !frame_start_in && !m_loading);
      m_acc = byte_vld_in && (frame_start_in || m_loading);
      m_next_commit = 0;
      if (frame_start_in) begin m_pos = 0; m_loading = 1; end
      e_layer = 0; e_addr = 0; e_ben = 0;
      if (m_acc) begin
        e_layer = 8'(1) << (m_pos / (P * B));
        e_addr  = 6'((m_pos / B) % P);
        e_ben   = 4'(1) << (m_pos % B);
        e_data  = byte_data_in;
        m_pos++;
        if (m_pos == FRAME) begin m_loading = 0; m_next_commit = 1; end
      end
      m_commit = m_next_commit;
      e_busy = m_loading || m_commit;
    end
  end

  // Compare process and strobe/pulse logging.
  always @(negedge clk_in) begin
    check("layer_en", 32'(layer_en_out), 32'(e_layer));
    check("wr_addr", 32'(wr_addr_out), 32'(e_addr));
    check("byte_en", 32'(byte_en_out), 32'(e_ben));
    check("byte_data", 32'(byte_data_out), 32'(e_data));
    check("frame_rdy", 32'(frame_rdy_out), 32'(e_rdy));
    check("busy", 32'(busy_out), 32'(e_busy));
    check("frame_err", 32'(frame_err_out), 32'(e_err));
    if (!rst_in) begin
      if (layer_en_out != 0) exp_q.push_back({layer_en_out, wr_addr_out, byte_en_out, byte_data_out});
      if (frame_rdy_out) rdy_cnt++;
      if (frame_err_out) err_cnt++;
    end
  end

  // Drive one cycle of inputs, starting and ending at posedge+1.
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    byte_vld_in = v; frame_start_in = s; byte_data_in = d;
    @(posedge clk_in); #1;
    byte_vld_in = 0; frame_start_in = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  task automatic bytes(input int first, input int n, input bit gapped);
    for (int i = first; i < first + n; i++) begin
      if (gapped && $urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      cyc(1, 0, 8'(i));
    end
  endtask

  int r0, e0;

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_layer_en", 32'(layer_en_out), 0);
    check("reset_busy", 32'(busy_out), 0);
    rst_in = 0;
    idle(2);

    // Full frame, back-to-back.
    exp_q.delete();
    cyc(0, 1, 0); bytes(0, FRAME, 0); idle(4);
    check("f1_count", exp_q.size(), FRAME);
    check("f1_b0", 32'(exp_q[0]), 32'(mk(8'h01, 6'd0, 4'b0001, 8'h00)));
    check("f1_b191", 32'(exp_q[191]), 32'(mk(8'h01, 6'd63, 4'b0100, 8'hBF)));
    check("f1_b192", 32'(exp_q[192]), 32'(mk(8'h02, 6'd0, 4'b0001, 8'hC0)));
    check("f1_last", 32'(exp_q[FRAME-1]), 32'(mk(8'h80, 6'd63, 4'b0100, 8'hFF)));
    check("f1_rdy_cnt", rdy_cnt, 1);
    check("f1_busy_low", 32'(busy_out), 0);

    // Same frame with random gaps.
    exp_q.delete();
    cyc(0, 1, 0); bytes(0, FRAME, 1); idle(4);
    check("f2_count", exp_q.size(), FRAME);
    check("f2_b191", 32'(exp_q[191]), 32'(mk(8'h01, 6'd63, 4'b0100, 8'hBF)));
    check("f2_last", 32'(exp_q[FRAME-1]), 32'(mk(8'h80, 6'd63, 4'b0100, 8'hFF)));
    check("f2_rdy_cnt", rdy_cnt, 2);

    // Abort after 500 bytes, then a complete frame.
    exp_q.delete(); r0 = rdy_cnt; e0 = err_cnt;
    cyc(0, 1, 0); bytes(0, 500, 0);
    cyc(0, 1, 0); bytes(0, FRAME, 0); idle(4);
    check("ab_count", exp_q.size(), 500 + FRAME);
    check("ab_b499", 32'(exp_q[499]), 32'(mk(8'h04, 6'd38, 4'b0010, 8'hF3)));
    check("ab_restart", 32'(exp_q[500]), 32'(mk(8'h01, 6'd0, 4'b0001, 8'h00)));
    check("ab_err_cnt", err_cnt - e0, 1);
    check("ab_rdy_cnt", rdy_cnt - r0, 1);

    // Stray bytes in IDLE, then a byte in the COMMIT cycle.
    exp_q.delete(); r0 = rdy_cnt; e0 = err_cnt;
    cyc(1, 0, 8'h11); idle(1); cyc(1, 0, 8'h22); cyc(1, 0, 8'h33); idle(2);
    check("idle_no_strobe", exp_q.size(), 0);
    check("idle_err_cnt", err_cnt - e0, 3);
    cyc(0, 1, 0); bytes(0, FRAME, 0); cyc(1, 0, 8'h44); idle(3);
    check("commit_drop_count", exp_q.size(), FRAME);
    check("commit_err_cnt", err_cnt - e0, 4);
    check("commit_rdy_cnt", rdy_cnt - r0, 1);

    // Start plus byte 0xA5 in the COMMIT cycle, then reset mid-frame at byte 1000.
    exp_q.delete(); r0 = rdy_cnt;
    cyc(0, 1, 0); bytes(0, FRAME, 0); cyc(1, 1, 8'hA5); idle(1);
    check("ca_rdy_cnt", rdy_cnt - r0, 1);
    check("ca_first", 32'(exp_q[FRAME]), 32'(mk(8'h01, 6'd0, 4'b0001, 8'hA5)));
    bytes(1, 999, 0);
    rst_in = 1; #1;
    check("rst_async_layer_en", 32'(layer_en_out), 0);
    check("rst_async_byte_en", 32'(byte_en_out), 0);
    check("rst_async_data", 32'(byte_data_out), 0);
    check("rst_async_busy", 32'(busy_out), 0);
    repeat (2) @(posedge clk_in);
    #1; rst_in = 0;
    exp_q.delete(); e0 = err_cnt;
    bytes(1000, 10, 0); idle(3);
    check("post_rst_no_strobe", exp_q.size(), 0);
    check("post_rst_err_cnt", err_cnt - e0, 10);
    check("post_rst_rdy_cnt", rdy_cnt - r0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
